// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared size/byte-enable encodings and response record for dm_arbiter
package dm_arbiter_pkg;

    localparam int DM_AW   = 11;
    localparam int WIN_LSB = DM_AW + 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dm_size_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Everything the response stage needs, captured on the accept edge.
    typedef struct packed {
        logic               valid;
        logic               mst;
        logic               we;
        logic [1:0]         size;
        logic               sgn;
        logic [31:WIN_LSB]  addr_hi;
        logic [1:0]         addr_lo;
        logic [31:0]        word;
    } dm_rsp_t;

endpackage

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - byte-enable generation, legality check and load-lane extraction
module dm_lane
    import dm_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:WIN_LSB] addr_hi,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [31:0]       rd,
    output logic [3:0]        be,
    output logic              legal,
    output logic [31:0]       ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        in_window;

    assign in_window = (addr_hi == BASE_ADDR[31:WIN_LSB]);
    assign byte_sel  = rd[{addr_lo, 3'b000} +: 8];
    assign half_sel  = addr_lo[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        be      = BE_NONE;
        legal   = 1'b0;
        ld_data = '0;
        case (size)
            SZ_BYTE: begin
                be      = BE_BYTE0 << addr_lo;
                legal   = 1'b1;
                ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be      = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                legal   = ~addr_lo[0];
                ld_data = {{16{sgn & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be      = BE_WORD;
                legal   = (addr_lo == 2'b00);
                ld_data = rd;
            end
            default: ;
        endcase
        // Misaligned or out-of-window accesses touch no lane and return zero.
        if (!(legal && in_window)) begin
            be      = BE_NONE;
            legal   = 1'b0;
            ld_data = '0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master round-robin data-memory arbiter; DM_ARB_LOCK_EN enables grant locking
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        M0_Req,
    input  logic        M0_We,
    input  logic [31:0] M0_Addr,
    input  logic [1:0]  M0_Size,
    input  logic        M0_Signed,
    input  logic [31:0] M0_WData,
    input  logic        M0_Lock,
    output logic        M0_Gnt,
    output logic        M0_RValid,
    output logic [31:0] M0_RData,
    output logic        M0_Err,
    input  logic        M1_Req,
    input  logic        M1_We,
    input  logic [31:0] M1_Addr,
    input  logic [1:0]  M1_Size,
    input  logic        M1_Signed,
    input  logic [31:0] M1_WData,
    input  logic        M1_Lock,
    output logic        M1_Gnt,
    output logic        M1_RValid,
    output logic [31:0] M1_RData,
    output logic        M1_Err,
    output logic        DM_We,
    output logic [10:0] DM_A,
    output logic [3:0]  DM_BE,
    output logic [31:0] DM_WD,
    input  logic [31:0] DM_RD
);

    logic        gnt0, gnt1, accept, sel;
    logic        lock_hold, lock_own;
    logic        rr_last;
    logic        m_we, m_sgn;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  req_be;
    logic        req_legal;
    logic [31:0] unused_req_ld;
    dm_rsp_t     rsp;
    logic [3:0]  unused_rsp_be;
    logic        rsp_legal;
    logic [31:0] rsp_ld, rsp_rdata;
    logic        rsp_err;

`ifdef DM_ARB_LOCK_EN
    logic lock_q, m_lock;

    assign m_lock    = sel ? M1_Lock : M0_Lock;
    assign lock_hold = lock_q && (lock_own ? (M1_Req && M1_Lock) : (M0_Req && M0_Lock));

    // Lock survives only while the owner keeps both Req and Lock asserted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lock_q   <= 1'b0;
            lock_own <= 1'b0;
        end else begin
            lock_q <= accept && m_lock;
            if (accept)
                lock_own <= sel;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = M0_Lock | M1_Lock;
    assign lock_hold   = 1'b0;
    assign lock_own    = 1'b0;
`endif

    // rr_last names the master granted most recently; the other wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (Rst_n) begin
            if (lock_hold) begin
                gnt0 = ~lock_own;
                gnt1 = lock_own;
            end else if (M0_Req && M1_Req) begin
                gnt0 = rr_last;
                gnt1 = ~rr_last;
            end else begin
                gnt0 = M0_Req;
                gnt1 = M1_Req;
            end
        end
    end

    assign M0_Gnt = gnt0;
    assign M1_Gnt = gnt1;
    assign accept = gnt0 | gnt1;
    assign sel    = gnt1;

    assign m_we    = sel ? M1_We     : M0_We;
    assign m_addr  = sel ? M1_Addr   : M0_Addr;
    assign m_size  = sel ? M1_Size   : M0_Size;
    assign m_sgn   = sel ? M1_Signed : M0_Signed;
    assign m_wdata = sel ? M1_WData  : M0_WData;

    dm_lane #(.BASE_ADDR(BASE_ADDR)) u_req_lane (
        .addr_hi (m_addr[31:WIN_LSB]),
        .addr_lo (m_addr[1:0]),
        .size    (m_size),
        .sgn     (m_sgn),
        .rd      (DM_RD),
        .be      (req_be),
        .legal   (req_legal),
        .ld_data (unused_req_ld)
    );

    assign DM_A  = m_addr[WIN_LSB-1:2];
    assign DM_WD = m_wdata;
    assign DM_We = accept && m_we && req_legal;
    assign DM_BE = DM_We ? req_be : BE_NONE;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rsp     <= '0;
            rr_last <= 1'b1;
        end else begin
            rsp.valid <= accept;
            if (accept) begin
                rr_last     <= sel;
                rsp.mst     <= sel;
                rsp.we      <= m_we;
                rsp.size    <= m_size;
                rsp.sgn     <= m_sgn;
                rsp.addr_hi <= m_addr[31:WIN_LSB];
                rsp.addr_lo <= m_addr[1:0];
                rsp.word    <= DM_RD;
            end
        end
    end

    dm_lane #(.BASE_ADDR(BASE_ADDR)) u_rsp_lane (
        .addr_hi (rsp.addr_hi),
        .addr_lo (rsp.addr_lo),
        .size    (rsp.size),
        .sgn     (rsp.sgn),
        .rd      (rsp.word),
        .be      (unused_rsp_be),
        .legal   (rsp_legal),
        .ld_data (rsp_ld)
    );

    assign rsp_rdata = (rsp.valid && !rsp.we) ? rsp_ld : '0;
    assign rsp_err   = rsp.valid && !rsp_legal;

    assign M0_RValid = rsp.valid && !rsp.mst;
    assign M1_RValid = rsp.valid &&  rsp.mst;
    assign M0_Err    = rsp_err && !rsp.mst;
    assign M1_Err    = rsp_err &&  rsp.mst;
    assign M0_RData  = rsp.mst ? 32'h0 : rsp_rdata;
    assign M1_RData  = rsp.mst ? rsp_rdata : 32'h0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter; lock checks follow DM_ARB_LOCK_EN
`timescale 1ns/1ps
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

`ifdef DM_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        M0_Req, M0_We, M0_Signed, M0_Lock, M0_Gnt, M0_RValid, M0_Err;
    logic [31:0] M0_Addr, M0_WData, M0_RData;
    logic [1:0]  M0_Size;
    logic        M1_Req, M1_We, M1_Signed, M1_Lock, M1_Gnt, M1_RValid, M1_Err;
    logic [31:0] M1_Addr, M1_WData, M1_RData;
    logic [1:0]  M1_Size;
    logic        DM_We;
    logic [10:0] DM_A;
    logic [3:0]  DM_BE;
    logic [31:0] DM_WD, DM_RD;
    logic [31:0] mem [0:2047];

    typedef struct {
        int          mst;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    dm_arbiter #(.BASE_ADDR(32'h0000_0000)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .M0_Req(M0_Req), .M0_We(M0_We), .M0_Addr(M0_Addr), .M0_Size(M0_Size),
        .M0_Signed(M0_Signed), .M0_WData(M0_WData), .M0_Lock(M0_Lock),
        .M0_Gnt(M0_Gnt), .M0_RValid(M0_RValid), .M0_RData(M0_RData), .M0_Err(M0_Err),
        .M1_Req(M1_Req), .M1_We(M1_We), .M1_Addr(M1_Addr), .M1_Size(M1_Size),
        .M1_Signed(M1_Signed), .M1_WData(M1_WData), .M1_Lock(M1_Lock),
        .M1_Gnt(M1_Gnt), .M1_RValid(M1_RValid), .M1_RData(M1_RData), .M1_Err(M1_Err),
        .DM_We(DM_We), .DM_A(DM_A), .DM_BE(DM_BE), .DM_WD(DM_WD), .DM_RD(DM_RD)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    assign DM_RD = mem[DM_A];
    always @(posedge Clk) begin
        if (DM_We)
            for (int b = 0; b < 4; b++)
                if (DM_BE[b]) mem[DM_A][8*b +: 8] <= DM_WD[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wd, input logic lck);
        if (m == 0) begin
            M0_Req = req; M0_We = we; M0_Addr = addr; M0_Size = size;
            M0_Signed = sgn; M0_WData = wd; M0_Lock = lck;
        end else begin
            M1_Req = req; M1_We = we; M1_Addr = addr; M1_Size = size;
            M1_Signed = sgn; M1_WData = wd; M1_Lock = lck;
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic access(input int m, input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n = 0;
        logic [31:0] a = addr;
        set_m(m, 1'b1, we, addr, size, sgn, wd, 1'b0);
        @(negedge Clk);
        while (((m == 0) ? M0_Gnt : M1_Gnt) !== 1'b1 && n < 20) begin
            n++;
            @(negedge Clk);
        end
        check("gnt_wait", n < 20, 1);
        check("dm_a", DM_A, a[12:2]);
        check("dm_wd", DM_WD, wd);
        check("dm_be", DM_BE, exp_be);
        check("dm_we", DM_We, we && !exp_err);
        sbq.push_back('{m, exp_rd, exp_err, cyc + 1});
        @(posedge Clk); #1;
        set_m(m, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
    endtask

    // One cycle of two-master word loads from 0x100 (M0) / 0x104 (M1); exp_g 2 = no grant.
    task automatic cycle2(input logic r0, input logic r1, input logic l1, input int exp_g, input bit push);
        set_m(0, r0, 1'b0, 32'h100, SZ_WORD, 1'b0, 32'h0, 1'b0);
        set_m(1, r1, 1'b0, 32'h104, SZ_WORD, 1'b0, 32'h0, l1);
        @(negedge Clk);
        check("arb_gnt0", M0_Gnt, exp_g == 0);
        check("arb_gnt1", M1_Gnt, exp_g == 1);
        if (push && exp_g == 0) sbq.push_back('{0, 32'h1111_0000, 1'b0, cyc + 1});
        if (push && exp_g == 1) sbq.push_back('{1, 32'h2222_0000, 1'b0, cyc + 1});
        @(posedge Clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, {M0_Gnt, M1_Gnt}, 0);
        check({tag, "_rvalid"}, {M0_RValid, M1_RValid}, 0);
        check({tag, "_err"}, {M0_Err, M1_Err}, 0);
        check({tag, "_rdata0"}, M0_RData, 0);
        check({tag, "_rdata1"}, M1_RData, 0);
        check({tag, "_dm_we"}, DM_We, 0);
        check({tag, "_dm_be"}, DM_BE, 0);
    endtask

    task automatic do_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h60, SZ_WORD, 1'b0, 32'hFFFF_FFFF, 1'b1);
        set_m(1, 1'b1, 1'b1, 32'h64, SZ_WORD, 1'b0, 32'hFFFF_FFFF, 1'b1);
        @(negedge Clk);
        check_quiet("reset");
        @(posedge Clk); #1;
        set_m(0, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        Rst_n = 1'b1;
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rst_n && (M0_RValid || M1_RValid)) begin
            check("rsp_single", M0_RValid & M1_RValid, 0);
            check("rsp_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rsp_master", M1_RValid, e.mst);
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_rdata", M1_RValid ? M1_RData : M0_RData, e.rd);
                check("rsp_err", M1_RValid ? M1_Err : M0_Err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // word store then load
        access(0, 1, 32'h10, SZ_WORD, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0);
        access(0, 0, 32'h10, SZ_WORD, 0, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0);

        // byte / half extraction
        access(0, 1, 32'h20, SZ_WORD, 0, 32'h80FF_7F01, 4'b1111, 32'h0, 0);
        access(0, 0, 32'h23, SZ_BYTE, 1, 32'h0, 4'b0000, 32'hFFFF_FF80, 0);
        access(1, 0, 32'h21, SZ_BYTE, 0, 32'h0, 4'b0000, 32'h0000_007F, 0);
        access(0, 0, 32'h22, SZ_HALF, 1, 32'h0, 4'b0000, 32'hFFFF_80FF, 0);
        access(1, 0, 32'h20, SZ_HALF, 0, 32'h0, 4'b0000, 32'h0000_7F01, 0);

        // byte store into an existing word
        access(1, 1, 32'h30, SZ_WORD, 0, 32'h1122_3344, 4'b1111, 32'h0, 0);
        access(1, 1, 32'h31, SZ_BYTE, 0, 32'hABAB_ABAB, 4'b0010, 32'h0, 0);
        access(1, 0, 32'h30, SZ_WORD, 0, 32'h0, 4'b0000, 32'h1122_AB44, 0);
        access(0, 1, 32'h36, SZ_HALF, 0, 32'h5A5A_5A5A, 4'b1100, 32'h0, 0);
        access(0, 0, 32'h34, SZ_WORD, 0, 32'h0, 4'b0000, 32'h5A5A_0000 | (mem[13] & 32'h0000_FFFF), 0);

        // illegal accesses leave memory untouched
        access(0, 1, 32'h40, SZ_WORD, 0, 32'h5555_AAAA, 4'b1111, 32'h0, 0);
        access(0, 1, 32'h00, SZ_WORD, 0, 32'hCAFE_F00D, 4'b1111, 32'h0, 0);
        access(1, 0, 32'h41, SZ_HALF, 1, 32'h0, 4'b0000, 32'h0, 1);
        access(0, 1, 32'h40, SZ_ILL,  0, 32'h1234_5678, 4'b0000, 32'h0, 1);
        access(1, 1, 32'h2000, SZ_WORD, 0, 32'h8765_4321, 4'b0000, 32'h0, 1);
        access(0, 1, 32'h42, SZ_WORD, 0, 32'h0BAD_0BAD, 4'b0000, 32'h0, 1);
        access(1, 0, 32'h40, SZ_WORD, 0, 32'h0, 4'b0000, 32'h5555_AAAA, 0);
        access(0, 0, 32'h00, SZ_WORD, 0, 32'h0, 4'b0000, 32'hCAFE_F00D, 0);

        // data for the contention and reset tests
        access(0, 1, 32'h100, SZ_WORD, 0, 32'h1111_0000, 4'b1111, 32'h0, 0);
        access(1, 1, 32'h104, SZ_WORD, 0, 32'h2222_0000, 4'b1111, 32'h0, 0);
        access(0, 1, 32'h54, SZ_WORD, 0, 32'h5454_5454, 4'b1111, 32'h0, 0);

        // reset right after an accepted store: response dropped, no write while reset low
        set_m(0, 1'b1, 1'b1, 32'h50, SZ_WORD, 1'b0, 32'h0000_0050, 1'b0);
        @(negedge Clk);
        check("pre_rst_gnt", M0_Gnt, 1);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h54, SZ_WORD, 1'b0, 32'hBAD0_BAD0, 1'b0);
        @(negedge Clk);
        check_quiet("mid_rst");
        @(posedge Clk); #1;
        set_m(0, 1'b0, 1'b0, 32'h0, SZ_BYTE, 1'b0, 32'h0, 1'b0);
        Rst_n = 1'b1;

        // contention straight out of reset
        for (int i = 0; i < 6; i++) cycle2(1, 1, 0, i % 2, 1);
        cycle2(0, 0, 0, 2, 1);

        access(1, 0, 32'h54, SZ_WORD, 0, 32'h0, 4'b0000, 32'h5454_5454, 0);
        access(1, 0, 32'h50, SZ_WORD, 0, 32'h0, 4'b0000, 32'h0000_0050, 0);

        // lock hold / release (alternation when lock is compiled out)
        do_reset();
        cycle2(0, 1, 1, 1, 1);
        cycle2(1, 1, 1, LOCK ? 1 : 0, 1);
        cycle2(1, 1, 1, 1, 1);
        cycle2(1, 0, 0, 0, 1);
        cycle2(1, 1, 0, 1, 1);
        cycle2(0, 1, 1, 1, 1);
        cycle2(1, 1, 1, LOCK ? 1 : 0, 0);
        Rst_n = 1'b0;
        @(negedge Clk);
        check("lock_rst_rvalid", {M0_RValid, M1_RValid}, 0);
        check("lock_rst_gnt", {M0_Gnt, M1_Gnt}, 0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        cycle2(1, 1, 1, 0, 1);
        cycle2(0, 0, 0, 2, 1);

        repeat (3) @(negedge Clk);
        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
